equiv_sweep_ctrl: RTL and testbench

- Self-checking sweep controller for combinational equivalence checks.
- On `start`, it steps a shared input vector through all 2^N_IN combinations. The vector drives both the design-under-test module and the golden module.
- After a settle delay it compares their single-bit outputs, counts mismatches and records the first failing vector.
- It replaces hand-written stimulus sequences in exercise benches; it is synthesizable so it can also run on board.

---
 rtl/equiv_sweep_ctrl.sv | 115 +++++++++++
 tb/tb_equiv_sweep_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_sweep_ctrl.sv
// Sweep controller for combinational equivalence checks: walks a shared input
// vector through every combination and logs where the DUT and golden outputs disagree.
module equiv_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            dut_m,
    input  logic            ref_m,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_t          r_state;
    logic [N_IN-1:0] r_vec;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_err_cnt;
    logic [N_IN-1:0] r_fail_vec;
    logic            r_fail_valid;
    logic [3:0]      r_settle;

    logic            w_mismatch;
    logic [N_IN:0]   w_err_next;

    // The count includes this cycle's mismatch so pass can be decided at the final CHECK edge.
    assign w_mismatch = dut_m ^ ref_m;
    assign w_err_next = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_vec        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
            r_settle     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_err_cnt    <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_settle     <= SETTLE_L;
                        r_state      <= (SETTLE_L == 4'd0) ? S_CHECK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_settle <= r_settle - 4'd1;
                    if (r_settle == 4'd1) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_err_cnt <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_vec   <= r_vec;
                        r_fail_valid <= 1'b1;
                    end
                    if (r_vec == VEC_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_vec    <= r_vec + 1'b1;
                        r_settle <= SETTLE_L;
                        r_state  <= (SETTLE_L == 4'd0) ? S_CHECK : S_WAIT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vec        = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err_cnt;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Bench for equiv_sweep_ctrl: three instances (default, zero settle, wider vector)
// checked every cycle against a sweep-timeline model plus literal expectations.
module tb_equiv_sweep_ctrl;

    localparam int NA = 3, SA = 1, TA = (1 << NA) * (SA + 1);
    localparam int NB = 3, SB = 0, TB = (1 << NB) * (SB + 1);
    localparam int NC = 4, SC = 3, TC = (1 << NC) * (SC + 1);

    typedef struct {
        logic [7:0] vec;
        logic       busy;
        logic       done;
        logic       pass;
        logic [8:0] err;
        logic [7:0] fv;
        logic       fvalid;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start;
    logic [15:0] dutTT;
    logic [15:0] refTT;

    logic [2:0] vecA, fvA;
    logic [3:0] errA;
    logic       dutMA, refMA, busyA, doneA, passA, fvalidA;
    logic [2:0] vecB, fvB;
    logic [3:0] errB;
    logic       dutMB, refMB, busyB, doneB, passB, fvalidB;
    logic [3:0] vecC, fvC;
    logic [4:0] errC;
    logic       dutMC, refMC, busyC, doneC, passC, fvalidC;

    int nCompared = 0;
    int nMismatched = 0;

    bit         stA = 0, stB = 0, stC = 0;
    int         eA = 0, eB = 0, eC = 0;
    logic [15:0] mmA = '0, mmB = '0, mmC = '0;

    int  kA, kB, k;
    logic stR, rsR;
    bit  sawDone;

    assign dutMA = dutTT[vecA];
    assign refMA = refTT[vecA];
    assign dutMB = dutTT[vecB];
    assign refMB = refTT[vecB];
    assign dutMC = dutTT[vecC];
    assign refMC = refTT[vecC];

    equiv_sweep_ctrl #(.N_IN(NA), .SETTLE(SA)) uA (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vecA), .dut_m(dutMA), .ref_m(refMA),
        .busy(busyA), .done(doneA), .pass(passA), .err_cnt(errA), .fail_vec(fvA), .fail_valid(fvalidA));
    equiv_sweep_ctrl #(.N_IN(NB), .SETTLE(SB)) uB (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vecB), .dut_m(dutMB), .ref_m(refMB),
        .busy(busyB), .done(doneB), .pass(passB), .err_cnt(errB), .fail_vec(fvB), .fail_valid(fvalidB));
    equiv_sweep_ctrl #(.N_IN(NC), .SETTLE(SC)) uC (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vecC), .dut_m(dutMC), .ref_m(refMC),
        .busy(busyC), .done(doneC), .pass(passC), .err_cnt(errC), .fail_vec(fvC), .fail_valid(fvalidC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isIdle(bit st, int e, int t);
        return !st || (e >= t + 1);
    endfunction

    function automatic bit allIdle();
        return isIdle(stA, eA, TA) && isIdle(stB, eB, TB) && isIdle(stC, eC, TC);
    endfunction

    // Timeline model: e counts edges since the start-sampling edge; the mismatch
    // mask is latched when the sweep begins.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stA <= 0; eA <= 0;
            stB <= 0; eB <= 0;
            stC <= 0; eC <= 0;
        end else begin
            if (isIdle(stA, eA, TA) && start) begin
                stA <= 1; eA <= 0; mmA <= dutTT ^ refTT;
            end else if (stA && eA < TA + 1) eA <= eA + 1;
            if (isIdle(stB, eB, TB) && start) begin
                stB <= 1; eB <= 0; mmB <= dutTT ^ refTT;
            end else if (stB && eB < TB + 1) eB <= eB + 1;
            if (isIdle(stC, eC, TC) && start) begin
                stC <= 1; eC <= 0; mmC <= dutTT ^ refTT;
            end else if (stC && eC < TC + 1) eC <= eC + 1;
        end
    end

    // A vector v is judged at edge (v+1)*(s+1), so after edge e the first e/(s+1) vectors are done.
    function automatic exp_t modelOut(int n, int s, bit st, int e, logic [15:0] mm);
        exp_t r;
        int total, c;
        r = '{default: '0};
        total = (1 << n) * (s + 1);
        if (!st) return r;
        if (e < total) begin
            c = e / (s + 1);
            r.vec = 8'(c);
            r.busy = 1'b1;
        end else begin
            c = 1 << n;
            r.vec = 8'((1 << n) - 1);
            r.done = (e == total);
        end
        for (int v = 0; v < c; v++) begin
            if (mm[v]) begin
                if (!r.fvalid) begin
                    r.fvalid = 1'b1;
                    r.fv = 8'(v);
                end
                r.err = r.err + 9'd1;
            end
        end
        if (e >= total) r.pass = (r.err == 9'd0);
        return r;
    endfunction

    task automatic compareField(input string name, input int act, input int req);
        nCompared++;
        if (act != req) begin
            nMismatched++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t ex, input logic [7:0] v,
                               input logic b, input logic d, input logic p,
                               input logic [8:0] er, input logic [7:0] fv, input logic fva);
        compareField({tag, ".vec"}, int'(v), int'(ex.vec));
        compareField({tag, ".busy"}, int'(b), int'(ex.busy));
        compareField({tag, ".done"}, int'(d), int'(ex.done));
        compareField({tag, ".pass"}, int'(p), int'(ex.pass));
        compareField({tag, ".err_cnt"}, int'(er), int'(ex.err));
        compareField({tag, ".fail_vec"}, int'(fv), int'(ex.fv));
        compareField({tag, ".fail_valid"}, int'(fva), int'(ex.fvalid));
    endtask

    task automatic checkAll();
        checkOutput("A", modelOut(NA, SA, stA, eA, mmA), 8'(vecA), busyA, doneA, passA, 9'(errA), 8'(fvA), fvalidA);
        checkOutput("B", modelOut(NB, SB, stB, eB, mmB), 8'(vecB), busyB, doneB, passB, 9'(errB), 8'(fvB), fvalidB);
        checkOutput("C", modelOut(NC, SC, stC, eC, mmC), 8'(vecC), busyC, doneC, passC, 9'(errC), 8'(fvC), fvalidC);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic rs);
        start = st;
        rst_n = rs;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        applyStimulus(1'b0, 1'b1);
        while (!allIdle() && n < 400) begin
            tick();
            n++;
        end
        if (!allIdle()) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL waitIdle actual=busy required=idle at %0t", $time);
        end
    endtask

    // Starts a sweep and reports the edge (start edge = 0) at which done is seen on A and B.
    task automatic runSweep(input int pulse0, input int pulse1, output int doneEdgeA, output int doneEdgeB);
        applyStimulus(1'b1, 1'b1);
        tick();
        start = 1'b0;
        doneEdgeA = -1;
        doneEdgeB = -1;
        for (int i = 1; i <= 200 && doneEdgeA < 0; i++) begin
            if (i == pulse0 || i == pulse1) start = 1'b1;
            tick();
            start = 1'b0;
            if (doneA && doneEdgeA < 0) doneEdgeA = i;
            if (doneB && doneEdgeB < 0) doneEdgeB = i;
        end
    endtask

    task automatic setBaseTables();
        for (int v = 0; v < 16; v++) dutTT[v] = (v[2] & v[1]) | v[0];
        refTT = dutTT;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                checkAll();
            end
        join_none

        start = 1'b0;
        rst_n = 1'b1;
        setBaseTables();
        #1 rst_n = 1'b0;
        tick();
        tick();
        compareField("reset.vecA", int'(vecA), 0);
        compareField("reset.busyA", int'(busyA), 0);
        compareField("reset.errA", int'(errA), 0);
        applyStimulus(1'b0, 1'b1);
        tick();

        $display("[TB] identical models");
        waitIdle();
        runSweep(-1, -1, kA, kB);
        compareField("t1.doneEdgeA", kA, 16);
        compareField("t1.passA", int'(passA), 1);
        compareField("t1.errA", int'(errA), 0);
        compareField("t1.fvalidA", int'(fvalidA), 0);
        waitIdle();
        compareField("t1.doneEdgeB", kB, 8);

        $display("[TB] single difference at 101");
        setBaseTables();
        refTT[5] = ~refTT[5];
        runSweep(-1, -1, kA, kB);
        compareField("t2.errA", int'(errA), 1);
        compareField("t2.fvA", int'(fvA), 5);
        compareField("t2.fvalidA", int'(fvalidA), 1);
        compareField("t2.passA", int'(passA), 0);

        $display("[TB] differences at 3 and 6 with start pulses while busy");
        waitIdle();
        setBaseTables();
        refTT[3] = ~refTT[3];
        refTT[6] = ~refTT[6];
        runSweep(3, 7, kA, kB);
        compareField("t3.doneEdgeA", kA, 16);
        compareField("t3.errA", int'(errA), 2);
        compareField("t3.fvA", int'(fvA), 3);
        waitIdle();
        runSweep(-1, -1, kA, kB);
        compareField("t3b.errA", int'(errA), 2);
        compareField("t3b.fvA", int'(fvA), 3);
        compareField("t3b.passA", int'(passA), 0);

        $display("[TB] inverted golden");
        waitIdle();
        setBaseTables();
        refTT = ~dutTT;
        runSweep(-1, -1, kA, kB);
        compareField("t4.errA", int'(errA), 8);
        compareField("t4.fvA", int'(fvA), 0);
        compareField("t4.passA", int'(passA), 0);

        $display("[TB] reset mid-sweep");
        waitIdle();
        applyStimulus(1'b1, 1'b1);
        tick();
        start = 1'b0;
        for (k = 0; k < 40 && vecA != 3'd4; k++) tick();
        compareField("t5.reachVec4", int'(vecA), 4);
        rst_n = 1'b0;
        #1;
        compareField("t5.rstVecA", int'(vecA), 0);
        compareField("t5.rstBusyA", int'(busyA), 0);
        compareField("t5.rstErrA", int'(errA), 0);
        compareField("t5.rstFvalidA", int'(fvalidA), 0);
        tick();
        rst_n = 1'b1;
        sawDone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (doneA) sawDone = 1;
        end
        compareField("t5.noDoneA", int'(sawDone), 0);
        setBaseTables();
        refTT[3] = ~refTT[3];
        runSweep(-1, -1, kA, kB);
        compareField("t5.doneEdgeA", kA, 16);
        compareField("t5.errA", int'(errA), 1);
        compareField("t5.fvA", int'(fvA), 3);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 12; r++) begin
            waitIdle();
            dutTT = 16'($urandom);
            case (r % 4)
                0: refTT = dutTT;
                1: refTT = ~dutTT;
                default: refTT = dutTT ^ 16'($urandom & $urandom & $urandom);
            endcase
            for (int c = 0; c < 150; c++) begin
                stR = (r == 5) ? 1'b1 : ($urandom_range(0, 7) == 0);
                rsR = ($urandom_range(0, 199) != 0);
                applyStimulus(stR, rsR);
                tick();
            end
            applyStimulus(1'b0, 1'b1);
        end
        waitIdle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
